// File: rtl/lab3_mem_line_mem_responder.sv
// lab3_mem_line_mem_responder: single-outstanding memory model for cache2mem val/rdy streams.
// Line (len 0) and word (len 4) read/write/write-init, response after p_latency BUSY cycles.
module lab3_mem_line_mem_responder #(
  parameter int p_num_lines = 64,
  parameter int p_latency   = 2
)(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_memreq_val,
  output logic         o_memreq_rdy,
  input  logic [2:0]   i_memreq_type,
  input  logic [7:0]   i_memreq_opaque,
  input  logic [31:0]  i_memreq_addr,
  input  logic [3:0]   i_memreq_len,
  input  logic [127:0] i_memreq_data,
  output logic         o_memresp_val,
  input  logic         i_memresp_rdy,
  output logic [2:0]   o_memresp_type,
  output logic [7:0]   o_memresp_opaque,
  output logic [1:0]   o_memresp_test,
  output logic [3:0]   o_memresp_len,
  output logic [127:0] o_memresp_data
);
  localparam int c_idx_w = $clog2(p_num_lines);
  localparam logic [7:0] c_cnt_init = 8'(p_latency > 0 ? p_latency - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_cnt, w_cnt_next;
  logic [3:0][31:0]   r_mem [p_num_lines];
  logic [2:0]         r_type;
  logic [7:0]         r_opaque;
  logic [1:0]         r_test;
  logic [3:0]         r_len;
  logic [127:0]       r_data;
  logic [c_idx_w-1:0] w_idx;
  logic [1:0]         w_word;
  logic               w_accept, w_ok, w_write, w_unused_addr;
  logic [3:0][31:0]   w_line, w_wr_line, w_rd_data;

  assign w_idx         = i_memreq_addr[4 +: c_idx_w];
  assign w_word        = i_memreq_addr[3:2];
  assign w_unused_addr = ^{i_memreq_addr[31:4+c_idx_w], i_memreq_addr[1:0]};
  assign o_memreq_rdy  = i_reset && r_state == S_IDLE;
  assign o_memresp_val = r_state == S_RESP;
  assign w_accept      = i_memreq_val && o_memreq_rdy;
  assign w_ok          = i_memreq_type <= 3'd2 && (i_memreq_len == 4'd0 || i_memreq_len == 4'd4);
  assign w_write       = w_ok && i_memreq_type != 3'd0;
  assign w_line        = r_mem[w_idx];

  // Word writes merge into the current line so the other three words survive.
  always_comb begin
    w_wr_line = i_memreq_len == 4'd0 ? i_memreq_data : w_line;
    if (i_memreq_len != 4'd0) w_wr_line[w_word] = i_memreq_data[31:0];
  end

  always_comb
    w_rd_data = (!w_ok || i_memreq_type != 3'd0) ? '0 :
                i_memreq_len == 4'd0 ? w_line : {96'd0, w_line[w_word]};

  always_ff @(posedge i_clk)
    if (w_accept && w_write) r_mem[w_idx] <= w_wr_line;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_next = p_latency > 0 ? S_BUSY : S_RESP;
        w_cnt_next   = c_cnt_init;
      end
      S_BUSY: begin
        w_state_next = r_cnt == 8'd0 ? S_RESP : S_BUSY;
        w_cnt_next   = r_cnt == 8'd0 ? 8'd0 : r_cnt - 8'd1;
      end
      S_RESP: if (i_memresp_rdy) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_type   <= '0;
      r_opaque <= '0;
      r_test   <= '0;
      r_len    <= '0;
      r_data   <= '0;
    end else if (w_accept) begin
      r_type   <= i_memreq_type;
      r_opaque <= i_memreq_opaque;
      r_test   <= w_ok ? 2'b00 : 2'b01;
      r_len    <= i_memreq_len;
      r_data   <= w_rd_data;
    end

  assign o_memresp_type   = r_type;
  assign o_memresp_opaque = r_opaque;
  assign o_memresp_test   = r_test;
  assign o_memresp_len    = r_len;
  assign o_memresp_data   = r_data;
endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// tb_lab3_mem_line_mem_responder: directed bench over three responders (p_latency 2, 0, 5)
// sharing request fields, each with its own val/rdy handshake.
module tb_lab3_mem_line_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   q_type;
  logic [7:0]   q_op;
  logic [31:0]  q_addr;
  logic [3:0]   q_len;
  logic [127:0] q_data;
  logic         q_val [3];
  logic         q_rdy [3];
  logic         p_rdy [3];
  logic         p_val [3];
  logic [2:0]   p_type [3];
  logic [7:0]   p_op [3];
  logic [1:0]   p_test [3];
  logic [3:0]   p_len [3];
  logic [127:0] p_data [3];

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] c_line   = 128'h44443333_22221111_DEADBEEF_CAFEF00D;
  localparam logic [127:0] c_merged = 128'h44443333_12345678_DEADBEEF_CAFEF00D;
  localparam logic [127:0] c_init   = 128'h01020304_A5A5A5A5_0BADF00D_77778888;
  localparam logic [127:0] c_d1     = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] c_d2     = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] c_aa     = {4{32'hAAAAAAAA}};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lab3_mem_line_mem_responder #(
      .p_num_lines(64),
      .p_latency(g == 0 ? 2 : g == 1 ? 0 : 5)
    ) u_dut (
      .i_clk(clk),
      .i_reset(rst_n),
      .i_memreq_val(q_val[g]),
      .o_memreq_rdy(q_rdy[g]),
      .i_memreq_type(q_type),
      .i_memreq_opaque(q_op),
      .i_memreq_addr(q_addr),
      .i_memreq_len(q_len),
      .i_memreq_data(q_data),
      .o_memresp_val(p_val[g]),
      .i_memresp_rdy(p_rdy[g]),
      .o_memresp_type(p_type[g]),
      .o_memresp_opaque(p_op[g]),
      .o_memresp_test(p_test[g]),
      .o_memresp_len(p_len[g]),
      .o_memresp_data(p_data[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic [2:0] t, input logic [7:0] op,
                     input logic [31:0] a, input logic [3:0] l, input logic [127:0] d);
    check("req_rdy", q_rdy[k], 1'b1);
    q_type = t; q_op = op; q_addr = a; q_len = l; q_data = d;
    q_val[k] = 1'b1;
    tick;
    q_val[k] = 1'b0;
  endtask

  // Counts edges after the accept edge until memresp_val is visible.
  task automatic wait_resp(input int k, input int lat);
    int n = 0;
    while (!p_val[k] && n < 30) begin
      tick;
      n++;
    end
    check("lat", 128'(n), 128'(lat));
  endtask

  task automatic finish_resp(input int k);
    p_rdy[k] = 1'b1;
    tick;
    p_rdy[k] = 1'b0;
    check("back_idle", q_rdy[k], 1'b1);
    check("val_drop", p_val[k], 1'b0);
  endtask

  task automatic txn(input string tag, input int k, input int lat, input logic [2:0] t,
                     input logic [7:0] op, input logic [31:0] a, input logic [3:0] l,
                     input logic [127:0] d, input logic [1:0] test, input logic [127:0] exp);
    req(k, t, op, a, l, d);
    wait_resp(k, lat);
    check({tag, "_type"}, p_type[k], t);
    check({tag, "_op"}, p_op[k], op);
    check({tag, "_test"}, p_test[k], test);
    check({tag, "_len"}, p_len[k], l);
    check({tag, "_data"}, p_data[k], exp);
    finish_resp(k);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 3; i++) begin
      q_val[i] = 1'b0;
      p_rdy[i] = 1'b0;
    end
    q_type = 3'd0; q_op = 8'h00; q_addr = 32'h0; q_len = 4'd0; q_data = '0;
    q_val[0] = 1'b1;
    repeat (3) tick;
    check("rst_rdy", q_rdy[0], 1'b0);
    check("rst_val", p_val[0], 1'b0);
    check("rst_fields", {p_type[0], p_op[0], p_test[0], p_len[0]}, '0);
    check("rst_data", p_data[0], '0);
    q_val[0] = 1'b0;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) check("rel_rdy", q_rdy[i], 1'b1);

    // Line and word traffic, p_latency=2
    txn("wr_line", 0, 2, 3'd1, 8'h05, 32'h0000_1040, 4'd0, c_line, 2'b00, '0);
    txn("rd_line", 0, 2, 3'd0, 8'h06, 32'h0000_1040, 4'd0, '0, 2'b00, c_line);
    txn("wr_word", 0, 2, 3'd1, 8'h07, 32'h0000_1048, 4'd4, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h12345678}, 2'b00, '0);
    txn("rd_merge", 0, 2, 3'd0, 8'h08, 32'h0000_1040, 4'd0, '0, 2'b00, c_merged);
    txn("rd_word", 0, 2, 3'd0, 8'h09, 32'h0000_104C, 4'd4, '0, 2'b00, 128'h44443333);
    txn("rd_alias", 0, 2, 3'd0, 8'h0A, 32'h0000_2047, 4'd0, '0, 2'b00, c_merged);
    txn("wr_init", 0, 2, 3'd2, 8'h0B, 32'h0000_1050, 4'd0, c_init, 2'b00, '0);
    txn("rd_init_w1", 0, 2, 3'd0, 8'h0C, 32'h0000_1057, 4'd4, '0, 2'b00, 128'h0BADF00D);

    // Backpressure: response held, new requests ignored
    req(0, 3'd0, 8'h33, 32'h0000_1040, 4'd0, '0);
    wait_resp(0, 2);
    q_type = 3'd1; q_op = 8'h77; q_addr = 32'h0000_1040; q_data = '1;
    q_val[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_val", p_val[0], 1'b1);
      check("bp_rdy", q_rdy[0], 1'b0);
      check("bp_op", p_op[0], 8'h33);
      check("bp_data", p_data[0], c_merged);
      tick;
    end
    q_val[0] = 1'b0;
    finish_resp(0);
    txn("bp_after", 0, 2, 3'd0, 8'h34, 32'h0000_1040, 4'd0, '0, 2'b00, c_merged);

    // Errors, p_latency=0
    txn("wr_d1", 1, 0, 3'd1, 8'h10, 32'h0000_0080, 4'd0, c_d1, 2'b00, '0);
    txn("err_len_rd", 1, 0, 3'd0, 8'h11, 32'h0000_0080, 4'd8, '0, 2'b01, '0);
    txn("err_len_wr", 1, 0, 3'd1, 8'h12, 32'h0000_0080, 4'd8, c_d2, 2'b01, '0);
    txn("err_type", 1, 0, 3'd3, 8'h13, 32'h0000_0080, 4'd0, c_d2, 2'b01, '0);
    txn("rd_unchanged", 1, 0, 3'd0, 8'h14, 32'h0000_0080, 4'd0, '0, 2'b00, c_d1);

    // Reset mid-BUSY, p_latency=5
    req(2, 3'd1, 8'h20, 32'h0000_0200, 4'd0, c_aa);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", p_val[2], 1'b0);
    check("mid_rst_rdy", q_rdy[2], 1'b0);
    check("mid_rst_fields", {p_type[2], p_op[2], p_test[2], p_len[2]}, '0);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (p_val[2]) seen = 1'b1;
    end
    check("no_stale_resp", seen, 1'b0);
    txn("rd_committed", 2, 5, 3'd0, 8'h21, 32'h0000_0200, 4'd0, '0, 2'b00, c_aa);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
